// File: rtl/n64_dd_regs_if.sv
// if_dd: link between the N64-side DD register front end and the CPU-side
// 64DD handler.
//   n64 modport : drives hard_reset, cmd_request, command, data_input,
//                 bm_request, bm_control; receives cmd_ack, status,
//                 data_output, bm_status.
//   cpu modport : the mirror image, for the CPU-side handler.
interface if_dd;
  logic        hard_reset;
  logic        cmd_request;
  logic [7:0]  command;
  logic [15:0] data_input;
  logic        bm_request;
  logic [15:0] bm_control;
  logic        cmd_ack;
  logic [15:0] status;
  logic [15:0] data_output;
  logic [15:0] bm_status;

  modport n64 (
    output hard_reset, cmd_request, command, data_input, bm_request, bm_control,
    input  cmd_ack, status, data_output, bm_status
  );

  modport cpu (
    input  hard_reset, cmd_request, command, data_input, bm_request, bm_control,
    output cmd_ack, status, data_output, bm_status
  );
endinterface

// File: rtl/n64_dd_regs.sv
// n64_dd_regs: N64-side register front end for 64DD emulation.
// Decodes PI halfword accesses in the DD ASIC register window and drives the
// N64 side of the if_dd link (commands, data, buffer-manager control, hard
// reset); reads back status, data and buffer-manager status from the CPU side.
//   clk, reset   : single clock, synchronous active-high reset
//   bus_address  : byte offset in the DD window (bit 0 ignored)
//   bus_read     : single-cycle read strobe
//   bus_write    : single-cycle write strobe
//   bus_wdata    : write halfword
//   bus_rdata    : read halfword, valid while bus_ack is high
//   bus_ack      : one-cycle acknowledge, one cycle after each strobe
//   dd           : if_dd.n64 link to the CPU-side handler
module n64_dd_regs #(
  parameter logic [15:0] HARD_RESET_KEY    = 16'hAAAA,
  parameter int unsigned HARD_RESET_CYCLES = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [7:0]  bus_address,
  input  logic        bus_read,
  input  logic        bus_write,
  input  logic [15:0] bus_wdata,
  output logic [15:0] bus_rdata,
  output logic        bus_ack,
  if_dd.n64           dd
);

  // Halfword selects (byte offset >> 1).
  localparam logic [6:0] SEL_DATA       = 7'h00;  // 0x00
  localparam logic [6:0] SEL_CMD        = 7'h04;  // 0x08
  localparam logic [6:0] SEL_BM         = 7'h08;  // 0x10
  localparam logic [6:0] SEL_HARD_RESET = 7'h10;  // 0x20
  localparam logic [6:0] SEL_DIAG       = 7'h1E;  // 0x3C

  // The counter holds the number of pulse cycles still to come after the
  // current one, so it is loaded with CYCLES-1 and the FSM leaves RESETTING
  // in the cycle it reads zero.
  localparam int CNT_W = (HARD_RESET_CYCLES > 1) ? $clog2(HARD_RESET_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(HARD_RESET_CYCLES - 1);

  typedef enum logic {
    IDLE,
    RESETTING
  } hr_state_e;

  hr_state_e        state;
  logic [CNT_W-1:0] cnt;

  logic        hard_reset_q;
  logic        cmd_request_q;
  logic [7:0]  command_q;
  logic [15:0] data_input_q;
  logic        bm_request_q;
  logic [15:0] bm_control_q;
  logic        overrun;

  logic [6:0]  sel;
  logic [15:0] read_value;
  logic        unused_addr_lsb;

  assign sel             = bus_address[7:1];
  assign unused_addr_lsb = bus_address[0];

  // Read mux; DIAG reflects the registered cmd_request/overrun of this cycle.
  always_comb begin
    // NOTE: default first so every path assigns read_value and no latch is inferred.
    read_value = '0;
    case (sel)
      SEL_DATA: read_value = dd.data_output;
      SEL_CMD:  read_value = dd.status;
      SEL_BM:   read_value = dd.bm_status;
      SEL_DIAG: read_value = {14'b0, overrun, cmd_request_q};
      default:  read_value = '0;
    endcase
  end

  // Bus response: one ack per strobe; a simultaneous write suppresses the
  // read, so bus_rdata only updates on read-only strobes.
  always_ff @(posedge clk) begin
    // NOTE: state is updated with non-blocking assignments so every register sees pre-edge values.
    if (reset) begin
      bus_ack   <= 1'b0;
      bus_rdata <= '0;
    end else begin
      bus_ack <= bus_read | bus_write;
      if (bus_read && !bus_write) begin
        bus_rdata <= read_value;
      end
    end
  end

  // Register file, command handshake and hard-reset FSM.
  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= IDLE;
      cnt           <= '0;
      hard_reset_q  <= 1'b0;
      cmd_request_q <= 1'b0;
      command_q     <= '0;
      data_input_q  <= '0;
      bm_request_q  <= 1'b0;
      bm_control_q  <= '0;
      overrun       <= 1'b0;
    end else begin
      bm_request_q <= 1'b0;
      if (cmd_request_q && dd.cmd_ack) begin
        cmd_request_q <= 1'b0;
      end

      case (state)
        IDLE: begin
          if (bus_write) begin
            case (sel)
              // DATA and CMD are dropped while a command is pending; the
              // decision uses the registered request, so a write in the same
              // cycle as cmd_ack is still dropped.
              SEL_DATA: begin
                if (cmd_request_q) overrun <= 1'b1;
                else               data_input_q <= bus_wdata;
              end
              SEL_CMD: begin
                if (cmd_request_q) begin
                  overrun <= 1'b1;
                end else begin
                  command_q     <= bus_wdata[7:0];
                  cmd_request_q <= 1'b1;
                end
              end
              SEL_BM: begin
                bm_control_q <= bus_wdata;
                bm_request_q <= 1'b1;
              end
              SEL_HARD_RESET: begin
                if (bus_wdata == HARD_RESET_KEY) begin
                  state         <= RESETTING;
                  cnt           <= CNT_LOAD;
                  hard_reset_q  <= 1'b1;
                  cmd_request_q <= 1'b0;
                  overrun       <= 1'b0;
                end
              end
              SEL_DIAG: begin
                if (bus_wdata[1]) overrun <= 1'b0;
              end
              default: ;
            endcase
          end
        end

        RESETTING: begin
          // Writes are ignored here; command/data/bm_control keep their values.
          cmd_request_q <= 1'b0;
          overrun       <= 1'b0;
          if (cnt == '0) begin
            state        <= IDLE;
            hard_reset_q <= 1'b0;
          end else begin
            cnt <= cnt - CNT_W'(1);
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

  assign dd.hard_reset  = hard_reset_q;
  assign dd.cmd_request = cmd_request_q;
  assign dd.command     = command_q;
  assign dd.data_input  = data_input_q;
  assign dd.bm_request  = bm_request_q;
  assign dd.bm_control  = bm_control_q;

endmodule
